contador_barrido: RTL and testbench

Parametrised display-scan counter that replaces the single-bit refresh toggle in the Gray decoder display path. It divides the system clock into per-digit time slots and walks a digit index across `NUM_DIGITOS` multiplexed 7-segment displays. It skips digits disabled by a mask and inserts a blanking interval at the start of each slot to suppress ghosting. It drives the anode lines and selects the 4-bit value presented to the downstream segment decoder.

---
 rtl/contador_barrido.sv | 112 +++++++++++
 tb/tb_contador_barrido.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/contador_barrido.sv
// contador_barrido: display-scan counter for multiplexed 7-segment digits.
// Splits the clock into per-digit slots, skips masked-off digits, blanks the
// start of every slot to suppress ghosting, and drives the anode lines plus
// the nibble handed to the segment decoder.
module contador_barrido #(
    parameter int NUM_DIGITOS  = 4,
    parameter int DIV_REFRESCO = 100000,
    parameter int BLANK_CICLOS = 2000,
    parameter bit ACTIVO_BAJO  = 1'b1,
    localparam int W_IDX = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1
) (
    input  logic                     reloj,
    input  logic                     reset,
    input  logic                     habilitar,
    input  logic [NUM_DIGITOS-1:0]   mascara,
    input  logic [4*NUM_DIGITOS-1:0] datos,
    output logic [NUM_DIGITOS-1:0]   anodos,
    output logic [W_IDX-1:0]         digito_actual,
    output logic [3:0]               nibble,
    output logic                     tick_barrido
);

    localparam int                W_CNT   = $clog2(DIV_REFRESCO);
    localparam logic [W_CNT-1:0]  CNT_MAX = W_CNT'(DIV_REFRESCO - 1);
    localparam logic [NUM_DIGITOS-1:0] ANODOS_OFF = {NUM_DIGITOS{ACTIVO_BAJO}};

    // Phase within a slot; derived from the count, not stored separately.
    typedef enum logic {
        APAGADO,
        MOSTRAR
    } fase_t;

    logic [W_CNT-1:0]       cnt_q, cnt_d;
    logic [W_IDX-1:0]       idx_q, idx_d;
    logic [W_IDX-1:0]       idx_nuevo;
    logic [NUM_DIGITOS-1:0] anodos_q, anodos_d;
    logic                   tick_q, tick_d;
    logic [NUM_DIGITOS-1:0] activo;
    fase_t                  fase_d;

    // Next enabled digit strictly after idx, wrapping; falls back to idx itself
    // when it is the only enabled digit (or when no digit is enabled).
    function automatic logic [W_IDX-1:0] siguiente(
        input logic [W_IDX-1:0]       idx,
        input logic [NUM_DIGITOS-1:0] mask
    );
        logic [W_IDX-1:0] res;
        logic             encontrado;
        int               j;
        res        = idx;
        encontrado = 1'b0;
        for (int k = 1; k <= NUM_DIGITOS; k++) begin
            j = (int'(idx) + k) % NUM_DIGITOS;
            if (!encontrado && mask[j]) begin
                res        = W_IDX'(j);
                encontrado = 1'b1;
            end
        end
        return res;
    endfunction

    assign idx_nuevo = siguiente(idx_q, mascara);

    // Next-state: slot count, digit advance, wrap pulse and anode pattern.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        tick_d = 1'b0;
        activo = '0;
        if (habilitar) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                // An empty mask holds the index and never reports a wrap.
                if (|mascara) begin
                    idx_d  = idx_nuevo;
                    tick_d = (idx_nuevo <= idx_q);
                end
            end else begin
                cnt_d = cnt_q + W_CNT'(1);
            end
        end
        fase_d = (int'(cnt_d) < BLANK_CICLOS) ? APAGADO : MOSTRAR;
        // Anodes use next-state count/index so they line up with them after the edge.
        if (habilitar && fase_d == MOSTRAR) begin
            activo[idx_d] = mascara[idx_d];
        end
        anodos_d = ACTIVO_BAJO ? ~activo : activo;
    end

    // State and registered outputs; reset wins over enable and any pending advance.
    always_ff @(posedge reloj) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            anodos_q <= ANODOS_OFF;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            anodos_q <= anodos_d;
            tick_q   <= tick_d;
        end
    end

    assign anodos        = anodos_q;
    assign digito_actual = idx_q;
    assign tick_barrido  = tick_q;
    assign nibble        = datos[{idx_q, 2'b00} +: 4];

endmodule

// File: tb/tb_contador_barrido.sv
// tb_contador_barrido: directed scoreboard bench for contador_barrido with
// NUM_DIGITOS=4, DIV_REFRESCO=8, BLANK_CICLOS=2, ACTIVO_BAJO=1.
module tb_contador_barrido;

    typedef struct {
        logic [3:0] an;
        logic [1:0] idx;
        logic       tick;
        logic [3:0] nib;
    } esperado_t;

    logic        reloj = 1'b0;
    logic        reset;
    logic        habilitar;
    logic [3:0]  mascara;
    logic [15:0] datos;
    logic [3:0]  anodos;
    logic [1:0]  digito_actual;
    logic [3:0]  nibble;
    logic        tick_barrido;

    int n_asserts = 0;
    int n_fails   = 0;

    esperado_t sb[$];
    // datos = 16'hA5C3 -> digits 0..3 carry 3, C, 5, A.
    logic [3:0] tabla_nib [4] = '{4'h3, 4'hC, 4'h5, 4'hA};

    contador_barrido #(
        .NUM_DIGITOS (4),
        .DIV_REFRESCO(8),
        .BLANK_CICLOS(2),
        .ACTIVO_BAJO (1'b1)
    ) dut (
        .reloj        (reloj),
        .reset        (reset),
        .habilitar    (habilitar),
        .mascara      (mascara),
        .datos        (datos),
        .anodos       (anodos),
        .digito_actual(digito_actual),
        .nibble       (nibble),
        .tick_barrido (tick_barrido)
    );

    always #5 reloj = ~reloj;

    task automatic check(input string nombre, input logic [31:0] got, input logic [31:0] want);
        n_asserts++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nombre, $time, got, want);
        end
    endtask

    // Wait for one active edge, then queue what the outputs must show after it.
    task automatic step(input logic [3:0] an, input int idx, input bit tick);
        esperado_t e;
        @(posedge reloj);
        #1;
        e.an   = an;
        e.idx  = 2'(idx);
        e.tick = tick;
        e.nib  = tabla_nib[idx];
        sb.push_back(e);
    endtask

    // Expected cycles of one slot of digit d, counts from_c..to_c:
    // dark for counts 0 and 1, lit from count 2 if lit=1; tick only on count 0.
    task automatic expect_slot(input int d, input int from_c, input int to_c,
                               input bit lit, input bit tick0);
        logic [3:0] on;
        on = 4'hF;
        on[d] = 1'b0;
        for (int c = from_c; c <= to_c; c++) begin
            step((lit && c >= 2) ? on : 4'hF, d, tick0 && (c == 0));
        end
    endtask

    task automatic reset_edge(input logic [3:0] m);
        reset   = 1'b1;
        mascara = m;
        step(4'hF, 0, 1'b0);
        reset = 1'b0;
    endtask

    // Monitor: compares every cycle for which an expectation was queued.
    initial begin
        esperado_t e;
        forever begin
            @(negedge reloj);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("anodos",        {28'd0, anodos},        {28'd0, e.an});
                check("digito_actual", {30'd0, digito_actual}, {30'd0, e.idx});
                check("tick_barrido",  {31'd0, tick_barrido},  {31'd0, e.tick});
                check("nibble",        {28'd0, nibble},        {28'd0, e.nib});
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        habilitar = 1'b1;
        mascara   = 4'b1111;
        datos     = 16'hA5C3;

        // Reset state held over two edges.
        step(4'hF, 0, 1'b0);
        reset_edge(4'b1111);

        // Full scan, two rounds: tick on each 3->0 wrap.
        expect_slot(0, 1, 7, 1, 0);
        expect_slot(1, 0, 7, 1, 0);
        expect_slot(2, 0, 7, 1, 0);
        expect_slot(3, 0, 7, 1, 0);
        expect_slot(0, 0, 7, 1, 1);
        expect_slot(1, 0, 7, 1, 0);
        expect_slot(2, 0, 7, 1, 0);
        expect_slot(3, 0, 7, 1, 0);
        expect_slot(0, 0, 7, 1, 1);
        expect_slot(1, 0, 7, 1, 0);

        // Freeze: enable low on the edge that would start count 4 of digit 2,
        // five dark frozen cycles, then counts 4..7 lit and advance to 3.
        expect_slot(2, 0, 3, 1, 0);
        habilitar = 1'b0;
        for (int i = 0; i < 5; i++) step(4'hF, 2, 1'b0);
        habilitar = 1'b1;
        expect_slot(2, 4, 7, 1, 0);
        expect_slot(3, 0, 7, 1, 0);
        expect_slot(0, 0, 7, 1, 1);

        // Empty mask mid-slot of digit 1: dark at once, index held, no tick.
        expect_slot(1, 0, 2, 1, 0);
        mascara = 4'b0000;
        for (int i = 0; i < 40; i++) step(4'hF, 1, 1'b0);
        // Count kept running: 2 + 40 = 42 -> count 2, so slot resumes at 3.
        mascara = 4'b1111;
        expect_slot(1, 3, 7, 1, 0);
        expect_slot(2, 0, 7, 1, 0);
        expect_slot(3, 0, 7, 1, 0);

        // Reset at count 7 of digit 3 beats the pending wrap and its tick.
        reset_edge(4'b1010);

        // Skip mask 1010: slot 0 dark, then 1,3,1,3 with tick on each 3->1.
        expect_slot(0, 1, 7, 0, 0);
        expect_slot(1, 0, 7, 1, 0);
        expect_slot(3, 0, 7, 1, 0);
        expect_slot(1, 0, 7, 1, 1);
        expect_slot(3, 0, 7, 1, 0);
        expect_slot(1, 0, 7, 1, 1);

        // Reset mid-lit at digit 2, count 5; restart from digit 0 blank.
        reset_edge(4'b1111);
        expect_slot(0, 1, 7, 1, 0);
        expect_slot(1, 0, 7, 1, 0);
        expect_slot(2, 0, 5, 1, 0);
        reset_edge(4'b1111);
        expect_slot(0, 1, 7, 1, 0);
        expect_slot(1, 0, 1, 1, 0);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge reloj);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
